// File: rtl/posit_round_pack.sv
// Posit output stage: builds the regime/exponent/fraction field, then rounds to
// nearest-even with saturation and packs the signed posit word. Two-stage valid/ready pipeline.
module posit_round_pack #(
    parameter int unsigned N  = 32,
    parameter int unsigned ES = 4,
    parameter int unsigned RS = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sign_in,
    input  logic signed [RS:0] k_in,
    input  logic [ES-1:0]      exp_in,
    input  logic [N-1:0]       mant_in,
    input  logic               inf_in,
    input  logic               zero_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       posit_out
);

    localparam int unsigned FW  = 2 * N;
    localparam int unsigned WW  = 2 * N + ES;
    localparam int unsigned SHW = $clog2(N);
    localparam int          NI  = int'(N);

    typedef struct packed {
        logic          sign;
        logic          inf;
        logic          zero;
        logic          sat_hi;
        logic          sat_lo;
        logic [FW-1:0] field;
    } s1_t;

    s1_t            s1_d;
    s1_t            s1_q;
    logic           s1_valid;
    logic           s2_adv;
    logic           s1_adv;
    logic [N-1:0]   posit_c;
    logic           hidden_unused;

    // The hidden bit is implied by the regime terminator and never encoded.
    assign hidden_unused = mant_in[N-1];

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // S1: regime run, exponent and fraction left-aligned; bits past 2N fold into the LSB.
    always_comb begin
        int              k_val;
        int              run_i;
        logic [SHW-1:0]  run;
        logic [WW-1:0]   body;
        logic [WW-1:0]   wide;

        k_val = int'(k_in);
        run_i = (k_val >= 0) ? k_val + 1 : -k_val;
        if (run_i > NI - 1) begin
            run_i = NI - 1;
        end
        run  = SHW'(run_i);
        body = {(k_val < 0), exp_in, mant_in[N-2:0], {N{1'b0}}};
        wide = body >> run;
        if (k_val >= 0) begin
            wide = wide | ~({WW{1'b1}} >> run);
        end

        s1_d        = '0;
        s1_d.sign   = sign_in;
        s1_d.inf    = inf_in;
        s1_d.zero   = zero_in;
        s1_d.sat_hi = (k_val >= NI - 2);
        s1_d.sat_lo = (k_val <= -(NI - 1));
        s1_d.field  = {wide[WW-1:ES+1], wide[ES] | (|wide[ES-1:0])};
    end

    // S2: round-to-nearest-even on the top N-1 bits, saturate, apply sign and specials.
    always_comb begin
        logic [N-2:0] mag;
        logic         guard;
        logic         sticky;
        logic         rnd;
        logic [N-1:0] sum;
        logic [N-1:0] mag_f;

        mag    = s1_q.field[FW-1 -: N-1];
        guard  = s1_q.field[N];
        sticky = |s1_q.field[N-1:0];
        rnd    = guard & (sticky | mag[0]);
        sum    = {1'b0, mag} + N'(rnd);

        if (s1_q.sat_hi || sum[N-1]) begin
            mag_f = {1'b0, {(N-1){1'b1}}};
        end else if (s1_q.sat_lo || (sum == '0)) begin
            mag_f = N'(1);
        end else begin
            mag_f = sum;
        end

        posit_c = s1_q.sign ? -mag_f : mag_f;
        if (s1_q.inf) begin
            posit_c = {1'b1, {(N-1){1'b0}}};
        end else if (s1_q.zero) begin
            posit_c = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            posit_out <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    posit_out <= posit_c;
                end
            end
        end
    end

endmodule
